key_bounce_gen: RTL and testbench

//  Emulates a mechanical push-button: on each accepted press request it drives a

---
 rtl/key_bounce_gen_if.sv | 38 +++
 rtl/key_bounce_gen.sv | 156 +++++++++++++++
 tb/tb_key_bounce_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/key_bounce_gen_if.sv
// key_bounce_gen_if: request and status bundle for the bouncing-key emulator.
//   press_valid_i  request a press sequence
//   press_ready_o  emulator idle, a request is accepted on this edge
//   hold_len_i     stable-pressed length in cycles, sampled on accept
//   key_o          emulated key, active-low
//   busy_o         press sequence in progress
//   done_stb_o     one-cycle strobe when a sequence finishes
// master = requester side, slave = emulator side.
interface key_bounce_gen_if #(
   parameter int unsigned HOLD_W = 16
) ();

   logic              press_valid_i;
   logic              press_ready_o;
   logic [HOLD_W-1:0] hold_len_i;
   logic              key_o;
   logic              busy_o;
   logic              done_stb_o;

   modport master (
      output press_valid_i,
      output hold_len_i,
      input  press_ready_o,
      input  key_o,
      input  busy_o,
      input  done_stb_o
   );

   modport slave (
      input  press_valid_i,
      input  hold_len_i,
      output press_ready_o,
      output key_o,
      output busy_o,
      output done_stb_o
   );

endinterface

// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulates a mechanical push-button in front of a debouncer.
// Each accepted request produces a glitch burst on press, a stable low hold, and a
// glitch burst on release. Glitch widths come from a 16-bit LFSR and are always
// shorter than the debouncer glitch window. key_o is active-low (idle 1).
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     key_bounce_gen_if.slave (request, hold length, key and status outputs)
module key_bounce_gen #(
   parameter int unsigned CLK_FREQ_MHZ   = 200,
   parameter int unsigned GLITCH_TIME_NS = 20,
   parameter int unsigned BOUNCE_PULSES  = 6,
   parameter int unsigned HOLD_W         = 16,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input logic             clk_i,
   input logic             rst_ni,
   key_bounce_gen_if.slave bus
);

   localparam int unsigned GLITCH_CYC = CLK_FREQ_MHZ * GLITCH_TIME_NS / 1000;
   // Guarded so an illegal configuration reports the error below instead of dividing by 0.
   localparam int unsigned GLITCH_M1  = (GLITCH_CYC > 1) ? GLITCH_CYC - 1 : 1;
   localparam int unsigned GC_BITS    = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
   localparam int unsigned CNT_W      = (HOLD_W > GC_BITS) ? HOLD_W : GC_BITS;
   localparam int unsigned PULSE_W    = (BOUNCE_PULSES > 1) ? $clog2(BOUNCE_PULSES) : 1;
   localparam logic [PULSE_W-1:0] LAST_PULSE =
      PULSE_W'((BOUNCE_PULSES == 0) ? 0 : BOUNCE_PULSES - 1);

   if (GLITCH_CYC < 2) begin : g_err_glitch
      $error("key_bounce_gen: GLITCH_CYC must be at least 2");
   end
   if (LFSR_SEED == 16'h0000) begin : g_err_seed
      $error("key_bounce_gen: LFSR_SEED must be nonzero");
   end

   typedef enum logic [2:0] {StIdle, StPressB, StHold, StRelB, StDone} state_e;

   state_e             state_q;
   logic [15:0]        lfsr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   hold_m1_q;
   logic [PULSE_W-1:0] pulse_q;
   logic               phase_q;   // 0: first half of a pulse, 1: second half
   logic               key_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;

   logic [15:0]      lfsr_next;
   logic [CNT_W-1:0] seg_m1;
   logic [CNT_W-1:0] hold_m1;

   // Fibonacci LFSR, taps 16,14,13,11.
   assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   // Segment width minus one; the counter runs down to 0 so the segment lasts seg_m1+1.
   assign seg_m1    = CNT_W'(32'(lfsr_q[7:0]) % GLITCH_M1);
   // A requested hold of 0 is stretched to 1 cycle.
   assign hold_m1   = (bus.hold_len_i == '0) ? '0 : CNT_W'(bus.hold_len_i - 1'b1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         lfsr_q    <= LFSR_SEED;
         cnt_q     <= '0;
         hold_m1_q <= '0;
         pulse_q   <= '0;
         phase_q   <= 1'b0;
         key_q     <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.press_valid_i) begin
                  hold_m1_q <= hold_m1;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  key_q     <= 1'b0;
                  pulse_q   <= '0;
                  phase_q   <= 1'b0;
                  if (BOUNCE_PULSES == 0) begin
                     state_q <= StHold;
                     cnt_q   <= hold_m1;
                  end else begin
                     state_q <= StPressB;
                     cnt_q   <= seg_m1;
                     lfsr_q  <= lfsr_next;
                  end
               end
            end
            // Both bursts toggle key_q at every segment boundary; they differ only in
            // the level they start from and where they go afterwards.
            StPressB, StRelB: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (!phase_q) begin
                  phase_q <= 1'b1;
                  key_q   <= ~key_q;
                  cnt_q   <= seg_m1;
                  lfsr_q  <= lfsr_next;
               end else if (pulse_q != LAST_PULSE) begin
                  pulse_q <= pulse_q + 1'b1;
                  phase_q <= 1'b0;
                  key_q   <= ~key_q;
                  cnt_q   <= seg_m1;
                  lfsr_q  <= lfsr_next;
               end else if (state_q == StPressB) begin
                  state_q <= StHold;
                  key_q   <= 1'b0;
                  cnt_q   <= hold_m1_q;
               end else begin
                  state_q <= StDone;
                  key_q   <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            StHold: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (BOUNCE_PULSES == 0) begin
                  state_q <= StDone;
                  key_q   <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= StRelB;
                  key_q   <= 1'b1;
                  pulse_q <= '0;
                  phase_q <= 1'b0;
                  cnt_q   <= seg_m1;
                  lfsr_q  <= lfsr_next;
               end
            end
            StDone: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               key_q   <= 1'b1;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.key_o         = key_q;
   assign bus.press_ready_o = ready_q;
   assign bus.busy_o        = busy_q;
   assign bus.done_stb_o    = done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// tb_key_bounce_gen: directed + randomized bench for key_bounce_gen.
// dut_a uses the default 6 bounce pulses, dut_b uses clean edges (0 pulses).
// The model expands each request into the expected per-cycle key/done waveform.
module tb_key_bounce_gen;

   localparam int unsigned GC   = 4;        // 200 MHz * 20 ns
   localparam int unsigned HW   = 16;
   localparam int unsigned SEED = 16'hACE1;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;

   always #5 clk_i = ~clk_i;

   key_bounce_gen_if #(.HOLD_W(HW)) bus_a ();
   key_bounce_gen_if #(.HOLD_W(HW)) bus_b ();

   key_bounce_gen #(.BOUNCE_PULSES(6), .HOLD_W(HW)) dut_a (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus_a.slave)
   );

   key_bounce_gen #(.BOUNCE_PULSES(0), .HOLD_W(HW)) dut_b (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus_b.slave)
   );

   int unsigned vectors;
   int unsigned miscompares;
   int unsigned m_lfsr;
   bit          exp_key[$];
   bit          exp_done[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic get_key(bit sel);
      return sel ? bus_b.key_o : bus_a.key_o;
   endfunction
   function automatic logic get_ready(bit sel);
      return sel ? bus_b.press_ready_o : bus_a.press_ready_o;
   endfunction
   function automatic logic get_busy(bit sel);
      return sel ? bus_b.busy_o : bus_a.busy_o;
   endfunction
   function automatic logic get_done(bit sel);
      return sel ? bus_b.done_stb_o : bus_a.done_stb_o;
   endfunction

   task automatic drive(input bit sel, input bit v, input logic [HW-1:0] h);
      if (sel) begin
         bus_b.press_valid_i = v;
         bus_b.hold_len_i    = h;
      end else begin
         bus_a.press_valid_i = v;
         bus_a.hold_len_i    = h;
      end
   endtask

   // One width draw, then the 16-bit shift register steps (taps 16,14,13,11).
   function automatic int unsigned draw_width();
      int unsigned w;
      int unsigned fb;
      w      = 1 + (m_lfsr % 256) % (GC - 1);
      fb     = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      m_lfsr = ((m_lfsr * 2) % 65536) + fb;
      return w;
   endfunction

   task automatic push_run(input int unsigned n, input bit k);
      for (int i = 0; i < int'(n); i++) begin
         exp_key.push_back(k);
         exp_done.push_back(1'b0);
      end
   endtask

   // Expected waveform from the cycle after acceptance through the done cycle.
   task automatic build_model(input int unsigned bp, input int unsigned h);
      int unsigned w;
      exp_key.delete();
      exp_done.delete();
      for (int p = 0; p < int'(bp); p++) begin
         w = draw_width(); push_run(w, 1'b0);
         w = draw_width(); push_run(w, 1'b1);
      end
      push_run((h == 0) ? 1 : h, 1'b0);
      for (int p = 0; p < int'(bp); p++) begin
         w = draw_width(); push_run(w, 1'b1);
         w = draw_width(); push_run(w, 1'b0);
      end
      exp_key.push_back(1'b1);
      exp_done.push_back(1'b1);
   endtask

   task automatic check_idle(input bit sel, input string tag);
      chk({tag, "_ready"}, 32'(get_ready(sel)), 32'd1);
      chk({tag, "_busy"},  32'(get_busy(sel)),  32'd0);
      chk({tag, "_key"},   32'(get_key(sel)),   32'd1);
      chk({tag, "_done"},  32'(get_done(sel)),  32'd0);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
   task automatic run_seq(input bit sel, input int unsigned bp, input int unsigned h,
                          input bit keep_valid);
      build_model(bp, h);
      drive(sel, 1'b1, HW'(h));
      chk("ready_before_accept", 32'(get_ready(sel)), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      // Junk hold value while busy must not affect the running sequence.
      drive(sel, keep_valid, HW'($urandom));
      for (int i = 0; i < exp_key.size(); i++) begin
         chk("key",        32'(get_key(sel)),   32'(exp_key[i]));
         chk("done_stb",   32'(get_done(sel)),  32'(exp_done[i]));
         chk("busy",       32'(get_busy(sel)),  32'd1);
         chk("ready_busy", 32'(get_ready(sel)), 32'd0);
         @(negedge clk_i);
      end
      check_idle(sel, "after_done");
   endtask

   initial begin
      int unsigned s;
      vectors     = 0;
      miscompares = 0;
      m_lfsr      = SEED;
      drive(1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, '0);

      // Reset and idle.
      repeat (3) @(negedge clk_i);
      check_idle(1'b0, "reset_a");
      check_idle(1'b1, "reset_b");
      rst_ni = 1'b1;
      repeat (50) begin
         @(negedge clk_i);
         check_idle(1'b0, "idle_a");
         check_idle(1'b1, "idle_b");
      end

      // Default bounce, hold 100.
      run_seq(1'b0, 6, 100, 1'b0);

      // Clean edges, including the zero-length hold stretched to 1.
      run_seq(1'b1, 0, 0, 1'b0);
      run_seq(1'b1, 0, 1, 1'b0);
      run_seq(1'b1, 0, $urandom_range(2, 40), 1'b0);

      // Request held high: three back-to-back sequences.
      for (int r = 0; r < 3; r++) run_seq(1'b0, 6, $urandom_range(0, 60), 1'b1);
      drive(1'b0, 1'b0, '0);
      @(negedge clk_i);
      check_idle(1'b0, "b2b_end");

      // Random holds with random idle gaps.
      for (int r = 0; r < 8; r++) begin
         run_seq(1'b0, 6, $urandom_range(0, 150), 1'b0);
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk_i);
            check_idle(1'b0, "gap");
         end
      end

      // Reset asserted mid-HOLD: key_o returns high without waiting for a clock edge.
      build_model(6, 100);
      s = (exp_key.size() - 101) / 2;
      drive(1'b0, 1'b1, HW'(100));
      @(posedge clk_i);
      @(negedge clk_i);
      drive(1'b0, 1'b0, '0);
      for (int i = 0; i < int'(s) + 50; i++) begin
         chk("pre_reset_key", 32'(get_key(1'b0)), 32'(exp_key[i]));
         @(negedge clk_i);
      end
      chk("in_hold_key", 32'(get_key(1'b0)), 32'd0);
      #1 rst_ni = 1'b0;
      #1 check_idle(1'b0, "async_reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (5) begin
         @(negedge clk_i);
         check_idle(1'b0, "post_reset");
      end
      // After reset the waveform must again follow the seed, as in the first bounce run.
      m_lfsr = SEED;
      run_seq(1'b0, 6, 100, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
